// File: rtl/mem_pkg.sv
// Shared definitions for the memory family: clear-engine state type,
// depth helper and read-latency legality check.
package mem_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    function automatic int depth(input int add_width);
        return 1 << add_width;
    endfunction

    function automatic bit read_latency_ok(input int read_latency);
        return (read_latency == 1) || (read_latency == 2);
    endfunction

endpackage

// File: rtl/mem_dp_clr_if.sv
// Request/response bundle of the clearable simple-dual-port memory.
interface mem_dp_clr_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADD_WIDTH  = 8
);
    logic                  write_en_in;
    logic [ADD_WIDTH-1:0]  write_addr_in;
    logic [DATA_WIDTH-1:0] write_data_in;
    logic                  read_en_in;
    logic [ADD_WIDTH-1:0]  read_addr_in;
    logic [DATA_WIDTH-1:0] read_data_out;
    logic                  read_valid_out;
    logic                  clear_req_in;
    logic                  busy_out;
    logic                  clear_done_out;

    modport master (
        output write_en_in, write_addr_in, write_data_in,
        output read_en_in, read_addr_in, clear_req_in,
        input  read_data_out, read_valid_out, busy_out, clear_done_out
    );

    modport slave (
        input  write_en_in, write_addr_in, write_data_in,
        input  read_en_in, read_addr_in, clear_req_in,
        output read_data_out, read_valid_out, busy_out, clear_done_out
    );
endinterface

// File: rtl/mem_clear_fsm.sv
// Clear engine: walks every address once after reset or on request and
// reports busy / done to the memory top.
module mem_clear_fsm
    import mem_pkg::*;
#(
    parameter int ADD_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_req_in,
    output logic                 busy_out,
    output logic                 clear_done_out,
    output logic                 clr_we,
    output logic [ADD_WIDTH-1:0] clr_addr
);

    clr_state_t           state, state_n;
    logic [ADD_WIDTH-1:0] clr_addr_n;
    logic                 done_n;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_CLEAR;
            clr_addr       <= '0;
            clear_done_out <= 1'b0;
        end else begin
            state          <= state_n;
            clr_addr       <= clr_addr_n;
            clear_done_out <= done_n;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_n    = state;
        clr_addr_n = clr_addr;
        done_n     = 1'b0;
        unique case (state)
            ST_CLEAR: begin
                clr_addr_n = clr_addr + ADD_WIDTH'(1);
                if (clr_addr == '1) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end
            ST_IDLE: begin
                if (clear_req_in) begin
                    state_n    = ST_CLEAR;
                    clr_addr_n = '0;
                end
            end
            default: state_n = ST_CLEAR;
        endcase
    end

    assign busy_out = (state == ST_CLEAR);
    assign clr_we   = busy_out && !rst;

endmodule

// File: rtl/mem_dp_clr.sv
// Simple-dual-port RAM with registered read, optional output register,
// selectable read-during-write behaviour and a built-in clear engine.
module mem_dp_clr
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADD_WIDTH    = 8,
    parameter int READ_LATENCY = 1,
    parameter int BYPASS       = 1
) (
    input logic         clk,
    input logic         rst,
    mem_dp_clr_if.slave bus
);

    localparam int DEPTH = depth(ADD_WIDTH);

    if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("mem_dp_clr: READ_LATENCY must be 1 or 2");
    end

    logic                  busy;
    logic                  clr_we;
    logic [ADD_WIDTH-1:0]  clr_addr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  mem_we;
    logic [ADD_WIDTH-1:0]  mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  bypass_hit;
    logic                  rd_valid_q1;
    logic [DATA_WIDTH-1:0] rd_data_q1;

    mem_clear_fsm #(.ADD_WIDTH(ADD_WIDTH)) u_clear_fsm (
        .clk            (clk),
        .rst            (rst),
        .clear_req_in   (bus.clear_req_in),
        .busy_out       (busy),
        .clear_done_out (bus.clear_done_out),
        .clr_we         (clr_we),
        .clr_addr       (clr_addr)
    );

    assign bus.busy_out = busy;

    // A clear request in the same cycle drops the user write; reads still go.
    assign wr_acc = !busy && !rst && bus.write_en_in && !bus.clear_req_in;
    assign rd_acc = !busy && !rst && bus.read_en_in;

    assign mem_we    = clr_we || wr_acc;
    assign mem_waddr = clr_we ? clr_addr : bus.write_addr_in;
    assign mem_wdata = clr_we ? '0 : bus.write_data_in;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; zeroing is
    // the clear engine's job.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bypass_hit = (BYPASS != 0) && wr_acc && (bus.write_addr_in == bus.read_addr_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q1 <= 1'b0;
            rd_data_q1  <= '0;
        end else begin
            rd_valid_q1 <= rd_acc;
            if (rd_acc) begin
                rd_data_q1 <= bypass_hit ? bus.write_data_in : mem[bus.read_addr_in];
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  rd_valid_q2;
        logic [DATA_WIDTH-1:0] rd_data_q2;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_valid_q2 <= 1'b0;
                rd_data_q2  <= '0;
            end else begin
                rd_valid_q2 <= rd_valid_q1;
                if (rd_valid_q1) begin
                    rd_data_q2 <= rd_data_q1;
                end
            end
        end

        assign bus.read_valid_out = rd_valid_q2;
        assign bus.read_data_out  = rd_data_q2;
    end else begin : g_lat1
        assign bus.read_valid_out = rd_valid_q1;
        assign bus.read_data_out  = rd_data_q1;
    end

endmodule

// File: doc/mem_dp_clr.md
# mem_dp_clr

- Parametrised simple-dual-port RAM: one write port, one read port, registered read data with a valid flag, selectable read-during-write behaviour.
- Built-in clear engine zeroes every entry, one address per cycle, after reset and on request.
- Successor to the team's basic dual-port memory; general-purpose line/coefficient store for the parallel FPGA datapath.

## Interface
- DATA_WIDTH, 8, word width in bits (≥1)
- ADD_WIDTH, 8, address width; DEPTH = 2**ADD_WIDTH entries
- READ_LATENCY, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register)
- BYPASS, 1, 1 = read-during-write to same address returns new data; 0 = returns old data

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- write_en_in  in  1  write request
- write_addr_in  in  ADD_WIDTH  write address
- write_data_in  in  DATA_WIDTH  write data
- read_en_in  in  1  read request
- read_addr_in  in  ADD_WIDTH  read address
- read_data_out  out  DATA_WIDTH  read data, valid when read_valid_out=1
- read_valid_out  out  1  one-cycle strobe per accepted read
- clear_req_in  in  1  request full memory clear
- busy_out  out  1  clear in progress; read/write requests ignored
- clear_done_out  out  1  one-cycle pulse when a clear completes

## Operation
- FSM states: ST_IDLE, ST_CLEAR. Clear address counter clr_addr is ADD_WIDTH bits.
- rst=1: state <= ST_CLEAR, clr_addr <= 0. Output values while rst=1: busy_out=1, read_valid_out=0, read_data_out=0, clear_done_out=0; read pipeline flushed.
- ST_CLEAR: each edge writes 0 to mem[clr_addr], clr_addr increments. On the edge writing DEPTH-1: state <= ST_IDLE, clr_addr wraps to 0.
- ST_IDLE: clear_req_in=1 → ST_CLEAR, clr_addr <= 0. Otherwise, normal accesses.
- Write accepted iff busy_out=0 and write_en_in=1 and clear_req_in=0. Clear wins over a simultaneous write; the write is dropped.
- Read accepted iff busy_out=0 and read_en_in=1. Reads are not blocked by a same-cycle clear_req_in; reads in flight when a clear starts drain normally with pre-clear data.
- Read-during-write, same address, same cycle: BYPASS=1 → write data; BYPASS=0 → previous content. Different addresses are independent.
- clear_req_in during ST_CLEAR: ignored; no restart, no extra done pulse.
- rst mid-clear: restart from address 0.
- read_data_out holds its last valid value when read_valid_out=0. It is never driven to Z.
- Out-of-range addresses are impossible: DEPTH is exactly 2**ADD_WIDTH.

## Timing
- Read latency: read accepted at edge N → read_valid_out=1 and data in the cycle after edge N+READ_LATENCY-1.
  - READ_LATENCY=1: valid the cycle after the request.
  - READ_LATENCY=2: valid two cycles after.
- Throughput: one read and one write per cycle.
- Clear duration: exactly DEPTH edges in ST_CLEAR.
  - From reset: first edge with rst=0 clears address 0. busy_out falls after DEPTH such edges. clear_done_out=1 for the first cycle with busy_out=0.
  - From request: clear_req_in sampled at edge E → busy_out=1 from E to E+DEPTH. busy_out=0 and clear_done_out=1 in the cycle after edge E+DEPTH.
- Requests presented in the clear_done_out cycle are accepted.

## Structure
- Package mem_pkg: state typedef (ST_IDLE, ST_CLEAR), READ_LATENCY legal-value check, and a depth function (2**ADD_WIDTH) shared with the other memories.
- Sub-module mem_clear_fsm: owns the state, clr_addr, busy_out and clear_done_out.
- Top module holds the storage array, write mux (clear vs. user), read pipeline and bypass compare.
- Storage is written as plain inferable RAM with no reset on the array. Zeroing is done only by the clear engine.

## Test plan
Configuration: DATA_WIDTH=8, ADD_WIDTH=4 (DEPTH=16).
- Reset release, then read all 16 addresses → busy_out low exactly 16 cycles after rst falls, one clear_done_out pulse, all reads return 0x00.
- Write 0xA5 to addr 3, then read addr 3 with READ_LATENCY=1 and =2 → 0xA5 with read_valid_out at cycle +1 and +2 respectively.
- Same cycle: write 0x3C to addr 7 and read addr 7 (old 0x11) → BYPASS=1 returns 0x3C; BYPASS=0 returns 0x11.
- Fill all addresses with 0xFF; assert clear_req_in together with a write to addr 2 → write dropped, busy_out high 16 cycles, writes and reads ignored, then every address reads 0x00.
- During clear: re-assert clear_req_in → no restart. Assert rst at clr_addr=9 → clear restarts at 0, busy_out high for a full 16 cycles.
- Back-to-back reads of addr 0..15 after writing data=addr → 16 consecutive valid strobes, data 0x00..0x0F in order, read_data_out held after the last read.
